// File: rtl/irq_src_pkg.sv
// rtl/irq_src_pkg.sv - shared state encoding and default constants for the interrupt request generator
package irq_src_pkg;

    // Per-line request state; 2'd3 is unused and falls back to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } line_state_t;

    localparam int DEF_N_IRQ           = 3;
    localparam int DEF_CNT_W           = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/irq_line.sv
// rtl/irq_line.sv - one request line: sync, optional debounce (IRQ_SRC_DEBOUNCE_EN), edge detect, handshake FSM, event queue
module irq_line
    import irq_src_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             irw,
    input  logic             ovf_clr,
    output logic             irq,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        s1;
    logic        s2;
    logic        filt;
    logic        filt_q;
    logic        evt;
    line_state_t state;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef IRQ_SRC_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;

    // Flip the filtered level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (s2 != filt) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                filt   <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end
`else
    assign filt = s2;
`endif

    // Previous filtered level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt;
        end
    end

    assign evt = filt & ~filt_q;

    // Handshake FSM with pending-event counter and sticky overflow; a new overflow beats ovf_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            irq      <= 1'b0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (ovf_clr) begin
                ovf <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (evt) begin
                        state <= ST_REQ;
                        irq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (irw) begin
                        state <= ST_WAIT;
                        irq   <= 1'b0;
                    end
                    if (evt) begin
                        if (pend_cnt == CNT_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            pend_cnt <= pend_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!irw) begin
                        // Release: a fresh event can stand in for the queued one being dequeued
                        if ((pend_cnt != '0) || evt) begin
                            state <= ST_REQ;
                            irq   <= 1'b1;
                            if (!evt) begin
                                pend_cnt <= pend_cnt - 1'b1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (evt) begin
                        if (pend_cnt == CNT_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            pend_cnt <= pend_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/irq_source.sv
// rtl/irq_source.sv - N_IRQ independent interrupt request lines (debounce via IRQ_SRC_DEBOUNCE_EN)
module irq_source
    import irq_src_pkg::*;
#(
    parameter int N_IRQ           = DEF_N_IRQ,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IRQ-1:0]       BTN,
    input  logic [N_IRQ-1:0]       IRW,
    input  logic                   OVF_CLR,
    output logic [N_IRQ-1:0]       IRQ,
    output logic [N_IRQ*CNT_W-1:0] PEND_CNT,
    output logic [N_IRQ-1:0]       OVF
);

    // One self-contained line per request; the top only slices buses
    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irq_line #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .btn      (BTN[i]),
            .irw      (IRW[i]),
            .ovf_clr  (OVF_CLR),
            .irq      (IRQ[i]),
            .pend_cnt (PEND_CNT[i*CNT_W +: CNT_W]),
            .ovf      (OVF[i])
        );
    end

endmodule
